// File: rtl/imm_pipe_gen_pkg.sv
// imm_pipe_gen_pkg
// Shared definitions for the pipelined immediate generator:
//   - imm_fmt_e    : format code presented on o_fmt (NONE/I/S/B/U/J/Z)
//   - buf_state_e  : occupancy state of the 2-entry output skid buffer
//   - OPC_*        : RV32/RV64 base opcodes, extended with U, J, SYSTEM,
//                    OP and MISC-MEM
//   - is_no_imm_opcode : helper naming the opcodes that are legal but
//                    carry no immediate
// Optional feature macro: IMM_CSR_EN (CSR zero-extended immediate, format Z).
package imm_pipe_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  // Encoding equals the number of entries held.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Opcodes that are recognised but have no immediate operand. SYSTEM is
  // listed here too; the CSR-immediate variant is handled by the decoder.
  function automatic logic is_no_imm_opcode(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_MISC_MEM) ||
           (opcode == OPC_SYSTEM);
  endfunction

endpackage

// File: rtl/imm_pipe_gen_decode.sv
// imm_decode
// Combinational immediate decoder: raw 32-bit instruction -> extended
// immediate, format code and illegal-opcode flag.
// Parameters:
//   XLEN        : immediate output width (32 or 64)
// Ports:
//   instruction : in  [31:0]      raw instruction word
//   imm         : out [XLEN-1:0]  sign/zero-extended immediate
//   fmt         : out imm_fmt_e   format code
//   illegal     : out             opcode not recognised
// Optional feature macro: IMM_CSR_EN. When defined, SYSTEM instructions with
// funct3[2] = 1 (csrr*i) produce format Z with the 5-bit rs1 field as a
// zero-extended immediate. Otherwise all SYSTEM instructions decode as NONE.
module imm_decode
  import imm_pipe_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]        opcode;
  logic signed [31:0] sext32;  // every signed format fits in 32 bits
  logic              zimm_sel;
  logic              unused_funct3;

  assign opcode = instruction[6:0];

  // funct3[1:0] never matters here; funct3[2] only with IMM_CSR_EN.
  assign unused_funct3 = ^instruction[14:12];

  always_comb begin
    sext32   = 32'sd0;
    fmt      = FMT_NONE;
    illegal  = 1'b0;
    zimm_sel = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        fmt    = FMT_I;
        sext32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      OPC_STORE: begin
        fmt    = FMT_S;
        sext32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OPC_BRANCH: begin
        fmt    = FMT_B;
        sext32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt    = FMT_U;
        sext32 = {instruction[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt    = FMT_J;
        sext32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
      end
      default: begin
        if (is_no_imm_opcode(opcode)) begin
`ifdef IMM_CSR_EN
          if ((opcode == OPC_SYSTEM) && instruction[14]) begin
            fmt      = FMT_Z;
            zimm_sel = 1'b1;
          end
`endif
        end else begin
          illegal = 1'b1;
        end
      end
    endcase
  end

  // A signed 32-bit source extends from bit 31, which makes RV64 U-type
  // sign-extend from bit 31 as required. The CSR immediate is unsigned.
  assign imm = zimm_sel ? XLEN'(instruction[19:15]) : XLEN'(sext32);

endmodule

// File: rtl/imm_pipe_gen.sv
// imm_pipe_gen
// Pipelined immediate generator for the decode stage. The combinational
// decoder result and a sideband tag are captured on acceptance into a
// 2-entry skid buffer and presented downstream behind valid/ready.
// Parameters:
//   XLEN  : immediate width, 32 or 64 (default `WORD_SIZE, 32 if undefined)
//   TAG_W : sideband tag width
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_flush               : synchronous flush, drops all buffered entries
//   i_valid, o_ready      : upstream handshake
//   i_instruction, i_tag  : instruction word and its tag
//   o_valid, i_ready      : downstream handshake
//   o_imm, o_fmt, o_illegal, o_tag : output entry (always the main register)
//   dbg_state             : buffer state (entries held) for observation
// Optional feature macro: IMM_CSR_EN (see imm_decode).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream, o_ready is a register that depends only on the buffer
// state, never combinationally on i_ready. Downstream, o_valid and the output
// fields stay stable until i_ready is seen high with o_valid.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module imm_pipe_gen
  import imm_pipe_gen_pkg::*;
#(
  parameter int XLEN  = `WORD_SIZE,
  parameter int TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instruction,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag,
  output logic [1:0]       dbg_state
);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_pipe_gen: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_illegal;

  buf_state_e       state;
  logic             ready_q;
  logic             accept;

  logic [XLEN-1:0]  skid_imm;
  imm_fmt_e         skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instruction(i_instruction),
    .imm        (dec_imm),
    .fmt        (dec_fmt),
    .illegal    (dec_illegal)
  );

  assign accept = i_valid && ready_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= BUF_EMPTY;
      ready_q      <= 1'b1;
      o_imm        <= '0;
      o_fmt        <= FMT_NONE;
      o_illegal    <= 1'b0;
      o_tag        <= '0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else if (i_flush) begin
      // Flush wins over any accept or consume in the same cycle.
      state   <= BUF_EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            o_imm     <= dec_imm;
            o_fmt     <= dec_fmt;
            o_illegal <= dec_illegal;
            o_tag     <= i_tag;
            state     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && i_ready) begin
            // Consume and refill in the same cycle: no bubble.
            o_imm     <= dec_imm;
            o_fmt     <= dec_fmt;
            o_illegal <= dec_illegal;
            o_tag     <= i_tag;
          end else if (accept) begin
            // Downstream stalled: park the new entry, main stays stable.
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
            skid_tag     <= i_tag;
            state        <= BUF_FULL;
            ready_q      <= 1'b0;
          end else if (i_ready) begin
            state <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (i_ready) begin
            o_imm     <= skid_imm;
            o_fmt     <= skid_fmt;
            o_illegal <= skid_illegal;
            o_tag     <= skid_tag;
            state     <= BUF_ONE;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state   <= BUF_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = (state != BUF_EMPTY);
  assign dbg_state = state;

endmodule

// File: tb/tb_imm_pipe_gen.sv
// tb_imm_pipe_gen
// Drives a 32-bit and a 64-bit instance with identical stimulus. A queue of
// expected entries models the 2-entry buffer; a monitor checks handshake
// signals every cycle and compares/pops the head entry on each transfer.
module tb_imm_pipe_gen;

  localparam int TAG_W = 32;
  localparam int EW    = 64 + 3 + 1 + TAG_W;  // {imm64, fmt, illegal, tag}

  logic             clk;
  logic             rst;
  logic             i_flush;
  logic             i_valid;
  logic             i_ready;
  logic [31:0]      i_instruction;
  logic [TAG_W-1:0] i_tag;

  logic             o_ready32, o_valid32, o_illegal32;
  logic [31:0]      o_imm32;
  logic [2:0]       o_fmt32;
  logic [TAG_W-1:0] o_tag32;
  logic [1:0]       state32;

  logic             o_ready64, o_valid64, o_illegal64;
  logic [63:0]      o_imm64;
  logic [2:0]       o_fmt64;
  logic [TAG_W-1:0] o_tag64;
  logic [1:0]       state64;

  logic [EW-1:0]    exp_q[$];
  int               held;
  int               checks;
  int               failures;

  imm_pipe_gen #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready32), .i_instruction(i_instruction), .i_tag(i_tag),
    .o_valid(o_valid32), .i_ready(i_ready), .o_imm(o_imm32),
    .o_fmt(o_fmt32), .o_illegal(o_illegal32), .o_tag(o_tag32),
    .dbg_state(state32)
  );

  imm_pipe_gen #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready64), .i_instruction(i_instruction), .i_tag(i_tag),
    .o_valid(o_valid64), .i_ready(i_ready), .o_imm(o_imm64),
    .o_fmt(o_fmt64), .o_illegal(o_illegal64), .o_tag(o_tag64),
    .dbg_state(state64)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Immediate value as a plain signed integer, then wrapped to 64 bits.
  function automatic logic [EW-1:0] model(input logic [31:0] ins,
                                          input logic [TAG_W-1:0] tag);
    longint v;
    logic [2:0] f;
    logic ill;
    v = 0; f = 3'd0; ill = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        f = 3'd1;
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'b0100011: begin
        f = 3'd2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'b1100011: begin
        f = 3'd3;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
            longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'b0110111, 7'b0010111: begin
        f = 3'd4;
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
      end
      7'b1101111: begin
        f = 3'd5;
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
            longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      7'b0110011, 7'b0001111: ;
      7'b1110011: begin
`ifdef IMM_CSR_EN
        if (ins[14]) begin
          f = 3'd6;
          v = longint'(ins[19:15]);
        end
`endif
      end
      default: ill = 1'b1;
    endcase
    return {v[63:0], f, ill, tag};
  endfunction

  // ---------------- scoreboard: push on acceptance ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 0;
      exp_q.delete();
    end else if (i_flush) begin
      held <= 0;
      exp_q.delete();
    end else begin
      if (i_valid && (held < 2))
        exp_q.push_back(model(i_instruction, i_tag));
      held <= held + ((i_valid && (held < 2)) ? 1 : 0)
                   - (((held > 0) && i_ready) ? 1 : 0);
    end
  end

  // ---------------- monitor: compare and pop on transfer ----------------
  logic        hold_pending;
  logic [63:0] hold_imm64;
  logic [TAG_W-1:0] hold_tag;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      chk("o_valid32", 64'(o_valid32), 64'(held > 0));
      chk("o_valid64", 64'(o_valid64), 64'(held > 0));
      chk("o_ready32", 64'(o_ready32), 64'(held < 2));
      chk("o_ready64", 64'(o_ready64), 64'(held < 2));
      chk("state32",   64'(state32),   64'(held));
      chk("state64",   64'(state64),   64'(held));
      if (hold_pending && o_valid64) begin
        chk("stable_imm64", o_imm64, hold_imm64);
        chk("stable_tag",   64'(o_tag64), 64'(hold_tag));
      end
      if (held > 0) begin
        if (exp_q.size() == 0) begin
          chk("queue_nonempty", 64'd0, 64'd1);
        end else begin
          e = exp_q[0];
          chk("imm32",     64'(o_imm32),     64'(e[EW-1 -: 64] & 64'hFFFF_FFFF));
          chk("imm64",     o_imm64,          e[EW-1 -: 64]);
          chk("fmt32",     64'(o_fmt32),     64'(e[TAG_W+3 -: 3]));
          chk("fmt64",     64'(o_fmt64),     64'(e[TAG_W+3 -: 3]));
          chk("illegal32", 64'(o_illegal32), 64'(e[TAG_W]));
          chk("illegal64", 64'(o_illegal64), 64'(e[TAG_W]));
          chk("tag32",     64'(o_tag32),     64'(e[TAG_W-1:0]));
          chk("tag64",     64'(o_tag64),     64'(e[TAG_W-1:0]));
          if (i_ready) void'(exp_q.pop_front());
        end
      end
      hold_pending = o_valid64 && !i_ready && !i_flush;
      hold_imm64   = o_imm64;
      hold_tag     = o_tag64;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
    i_valid       = 1'b1;
    i_instruction = ins;
    i_tag         = tag;
    step();
    i_valid       = 1'b0;
  endtask

  // ---------------- directed known-answer table ----------------
  localparam int ND = 9;
  logic [31:0] d_ins [ND];
  logic [63:0] d_imm [ND];
  logic [2:0]  d_fmt [ND];
  logic        d_ill [ND];

  initial begin
    d_ins[0] = 32'hFFF0_0093; d_imm[0] = 64'hFFFF_FFFF_FFFF_FFFF; d_fmt[0] = 3'd1; d_ill[0] = 1'b0;
    d_ins[1] = 32'hFE00_0EE3; d_imm[1] = 64'hFFFF_FFFF_FFFF_FFFC; d_fmt[1] = 3'd3; d_ill[1] = 1'b0;
    d_ins[2] = 32'h1234_50B7; d_imm[2] = 64'h0000_0000_1234_5000; d_fmt[2] = 3'd4; d_ill[2] = 1'b0;
    d_ins[3] = 32'h0080_006F; d_imm[3] = 64'h0000_0000_0000_0008; d_fmt[3] = 3'd5; d_ill[3] = 1'b0;
`ifdef IMM_CSR_EN
    d_ins[4] = 32'h3002_D073; d_imm[4] = 64'h5;                   d_fmt[4] = 3'd6; d_ill[4] = 1'b0;
`else
    d_ins[4] = 32'h3002_D073; d_imm[4] = 64'h0;                   d_fmt[4] = 3'd0; d_ill[4] = 1'b0;
`endif
    d_ins[5] = 32'h0000_007F; d_imm[5] = 64'h0;                   d_fmt[5] = 3'd0; d_ill[5] = 1'b1;
    d_ins[6] = 32'hFE11_2E23; d_imm[6] = 64'hFFFF_FFFF_FFFF_FFFC; d_fmt[6] = 3'd2; d_ill[6] = 1'b0;
    d_ins[7] = 32'h8000_02B7; d_imm[7] = 64'hFFFF_FFFF_8000_0000; d_fmt[7] = 3'd4; d_ill[7] = 1'b0;
    d_ins[8] = 32'h0000_0033; d_imm[8] = 64'h0;                   d_fmt[8] = 3'd0; d_ill[8] = 1'b0;
  end

  logic [6:0] opc_tab [12];
  initial begin
    opc_tab[0]  = 7'b0000011; opc_tab[1]  = 7'b0010011; opc_tab[2]  = 7'b1100111;
    opc_tab[3]  = 7'b0100011; opc_tab[4]  = 7'b1100011; opc_tab[5]  = 7'b0110111;
    opc_tab[6]  = 7'b0010111; opc_tab[7]  = 7'b1101111; opc_tab[8]  = 7'b0110011;
    opc_tab[9]  = 7'b0001111; opc_tab[10] = 7'b1110011; opc_tab[11] = 7'b1110011;
  end

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_instruction = 32'h0; i_tag = '0;
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid32", 64'(o_valid32), 64'd0);
    chk("rst_ready32", 64'(o_ready32), 64'd1);
    chk("rst_imm64",   o_imm64,        64'd0);
    chk("rst_fmt32",   64'(o_fmt32),   64'd0);
    chk("rst_ill32",   64'(o_illegal32), 64'd0);
    chk("rst_tag64",   64'(o_tag64),   64'd0);
    rst = 1'b0;
    step();

    // Directed known answers, downstream always ready.
    i_ready = 1'b1;
    for (int i = 0; i < ND; i++) begin
      send(d_ins[i], 32'hC0DE_0000 | i);
      @(negedge clk);
      chk("kat_imm32", 64'(o_imm32), d_imm[i] & 64'hFFFF_FFFF);
      chk("kat_imm64", o_imm64,      d_imm[i]);
      chk("kat_fmt",   64'(o_fmt64), 64'(d_fmt[i]));
      chk("kat_ill",   64'(o_illegal32), 64'(d_ill[i]));
      chk("kat_tag",   64'(o_tag32), 64'(32'hC0DE_0000 | i));
      #1;
    end
    step();

    // Backpressure: two entries fill the buffer, then drain in order.
    i_ready = 1'b0;
    send(32'hFFF0_0093, 32'h0000_0A01);
    send(32'h1234_50B7, 32'h0000_0A02);
    @(negedge clk);
    chk("bp_ready_low", 64'(o_ready32), 64'd0);
    repeat (3) step();
    i_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("bp_drained_valid", 64'(o_valid64), 64'd0);
    chk("bp_drained_ready", 64'(o_ready64), 64'd1);
    #1;

    // Flush with a simultaneous valid while FULL.
    i_ready = 1'b0;
    send(32'h0080_006F, 32'h0000_0B01);
    send(32'hFE00_0EE3, 32'h0000_0B02);
    i_flush = 1'b1; i_valid = 1'b1; i_instruction = 32'hFFF0_0093; i_tag = 32'hB03;
    step();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(o_valid32), 64'd0);
    chk("flush_ready", 64'(o_ready32), 64'd1);
    #1;
    repeat (3) step();
    chk("flush_quiet", 64'(o_valid64), 64'd0);

    // Randomised traffic with random backpressure and rare flushes.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = opc_tab[$urandom_range(0, 11)];
      i_instruction = ins;
      i_tag         = $urandom;
      i_valid       = ($urandom_range(0, 3) != 0);
      i_ready       = ($urandom_range(0, 3) != 0);
      i_flush       = ($urandom_range(0, 49) == 0);
      step();
    end
    i_flush = 1'b0;

    // Asynchronous reset in the middle of a transfer.
    i_ready = 1'b0;
    send(32'h0010_0093, 32'h0000_0C01);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid32", 64'(o_valid32), 64'd0);
    chk("async_rst_valid64", 64'(o_valid64), 64'd0);
    chk("async_rst_ready",   64'(o_ready32), 64'd1);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(o_ready64), 64'd1);

    // Final drain.
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (4) step();
    chk("final_valid", 64'(o_valid32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_pipe_gen.md
# imm_pipe_gen

Parametrised, pipelined immediate generator for the decode stage. Covers every RV32/RV64 base immediate format (I, S, B, U, J), with optional CSR zero-extended immediate support. Output is registered behind a valid/ready handshake with a 2-entry skid buffer. A user tag (PC, ROB id) travels alongside each instruction, so the block drops between fetch and the register-read/ALU operand mux without adding a bubble.

## Interface
Parameters:
- `XLEN`, default `` `WORD_SIZE `` (32): output width; only 32 and 64 are legal.
- `TAG_W`, default 32: width of the sideband tag carried with each instruction.

Ports:
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_flush`  in  1  synchronous flush; drops all buffered entries.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  block can accept an instruction this cycle.
- `i_instruction`  in  32  raw instruction word.
- `i_tag`  in  TAG_W  sideband tag.
- `o_valid`  out  1  output entry valid.
- `i_ready`  in  1  downstream accepts the output entry.
- `o_imm`  out  XLEN  extended immediate.
- `o_fmt`  out  3  format code.
- `o_illegal`  out  1  opcode not recognised.
- `o_tag`  out  TAG_W  tag of the output entry.

## Operation
Decode is combinational on `i_instruction`; its result is captured on acceptance (`i_valid && o_ready`).

Decode by `opcode = i_instruction[6:0]`:

| Opcodes | Format | Immediate |
|---|---|---|
| 0000011, 0010011, 1100111 | I | `ins[31:20]` |
| 0100011 | S | `{ins[31:25], ins[11:7]}` |
| 1100011 | B | `{ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}` |
| 0110111, 0010111 | U | `{ins[31:12], 12'b0}` |
| 1101111 | J | `{ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}` |
| 0110011, 0001111, 1110011 | NONE | 0 (except the CSR case below) |
| anything else | NONE | 0, with `o_illegal` = 1 |

Width and extension rules:
- I, S, B, U and J are sign-extended to `XLEN` from the top immediate bit.
- On RV64, U-type sign-extends from bit 31.

Buffer states (entries held):
- **EMPTY (0):**
  - Accept → ONE.
- **ONE (1):**
  - Accept with `i_ready` → stays ONE; the new entry replaces the consumed one.
  - Accept without `i_ready` → FULL; the new entry goes to the skid register.
  - `i_ready` without accept → EMPTY.
- **FULL (2):**
  - No accept is possible, because `o_ready` = 0.
  - `i_ready` → ONE; the skid entry moves to the main register.

Signal rules:
- `o_ready` is registered and equals the state not being FULL. It does not depend on `i_ready` combinationally.
- `o_valid` = state is not EMPTY.
- Output fields always come from the main register; order is strictly FIFO.
- `i_flush` moves the state to EMPTY next cycle. It has priority over a simultaneous accept (the input is dropped) and over a simultaneous `i_ready`.

## Timing
- Latency: accept in cycle N → `o_valid` with that entry in cycle N+1.
- Throughput: 1 instruction/cycle while `i_ready` = 1.
- While `o_valid` = 1 and `i_ready` = 0, all output fields hold stable.
- Reset values: state EMPTY, `o_valid` 0, `o_ready` 1, `o_imm` 0, `o_fmt` NONE, `o_illegal` 0, `o_tag` 0.
- Reset asserted mid-transfer discards all entries immediately (asynchronous).
- `o_ready` returns to 1 in the first cycle after reset deasserts.
- Flush: `o_valid` = 0 in the cycle after `i_flush`; `o_ready` = 1 in that same cycle.

## Configuration
- `IMM_CSR_EN` defined:
  - Opcode 1110011 with `funct3[2]` = 1 yields format Z.
  - Immediate is `{(XLEN-5)'b0, ins[19:15]}`, zero-extended.
- Not defined:
  - All 1110011 instructions yield NONE with immediate 0 and `o_illegal` = 0.
  - Format code Z is never produced.

## Structure
Shared package holds:
- Format codes: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- Opcode constants (extends `OPCODES_DEFINES.vh` with U, J, SYSTEM, OP, MISC-MEM).

Sub-module:
- `imm_decode`: a combinational decoder, instruction → {imm, fmt, illegal}.
- The top level contains only the 2-entry skid buffer and its control.

## Test plan
- `0xFFF00093` (addi x1,x0,-1), `i_ready` = 1 → next cycle `o_imm` = 0xFFFFFFFF, `o_fmt` I, `o_tag` echoed.
- `0xFE000EE3` (beq -4) → imm 0xFFFFFFFC, fmt B.
- `0x123450B7` (lui) → 0x12345000, fmt U.
- `0x0080006F` (jal +8) → 8, fmt J.
- With `XLEN` = 64, `0xFFF00093` → 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold `i_ready` = 0 and send 2 instructions → `o_ready` drops to 0 after the second accept, outputs stay stable. Release `i_ready` → both drain in order on consecutive cycles, then `o_ready` = 1.
- `0x3002D073` (csrrwi, zimm 5):
  - With `IMM_CSR_EN` → imm 5, fmt Z.
  - Without → imm 0, fmt NONE.
- `0x0000007F` → `o_illegal` = 1, imm 0.
- Assert `i_flush` together with `i_valid` while FULL → next cycle `o_valid` = 0, `o_ready` = 1, nothing emitted afterwards.
- Assert `i_rst` mid-stream → `o_valid` falls without waiting for a clock edge.
